// File: rtl/mlp_pkg.sv
// Shared constants and FSM state type for the MLP layer datapath blocks.
package mlp_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 9;
  localparam int N_NEURONS = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/bias_sat_add.sv
// Combinational signed accumulator + bias adder.
// Define BIAS_ADD_SAT_EN for saturating results; otherwise the sum wraps.
module bias_sat_add #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

`ifdef BIAS_ADD_SAT_EN
  logic [DATA_W:0] sum_ext;

  assign sum_ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};

  // Overflow shows up as disagreement between the sign and the extra sign bit.
  always_comb begin
    y = sum_ext[DATA_W-1:0];
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      y = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Low DATA_W bits of the widened sum are exactly the wrapped narrow sum.
  assign y = a + b;
`endif

endmodule

// File: rtl/bias_add_seq.sv
// Sequences one layer pass: adds a per-neuron bias to each accumulator word
// through a single output register with ready/valid flow control.
import mlp_pkg::*;

module bias_add_seq #(
  parameter int N_NEURONS = mlp_pkg::N_NEURONS,
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int ADDR_W    = mlp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_data,
  output logic              acc_ready,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0] bias_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [ADDR_W-1:0] out_idx_reg, out_idx_next;
  logic [DATA_W-1:0] sum;
  logic              xfer;

  bias_sat_add #(.DATA_W(DATA_W)) u_add (
    .a (acc_data),
    .b (bias_data),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_idx_reg   <= out_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_idx_next   = out_idx_reg;
    done           = 1'b0;
    acc_ready      = (state_reg == RUN) && (!out_valid_reg || out_ready);
    xfer           = acc_valid && acc_ready;

    // A fresh transfer in the same cycle as a drain keeps the register full.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
    if (xfer) begin
      out_valid_next = 1'b1;
      out_data_next  = sum;
      out_idx_next   = idx_reg;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DRAIN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!out_valid_reg || out_ready) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        idx_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bias_addr = idx_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_idx   = out_idx_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/bias_add_seq.md
BIAS_ADD_SEQ -- requirements
Module: bias_add_seq

Interface
REQ-001 The block SHALL have parameter N_NEURONS, default 15, number of neurons (bias entries) per layer pass.
REQ-002 The block SHALL have parameter DATA_W, default 16, width of signed two's-complement data and bias words.
REQ-003 The block SHALL have parameter ADDR_W, default 9, width of the bias register-file address.
REQ-004 The block SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse launching one layer pass.
REQ-007 acc_valid  input  1  accumulator word available.
REQ-008 acc_data  input  DATA_W  signed MAC accumulator result for current neuron.
REQ-009 acc_ready  output  1  block accepts acc_data this cycle.
REQ-010 bias_addr  output  ADDR_W  read address to bias register file (combinational read).
REQ-011 bias_data  input  DATA_W  bias word returned for bias_addr in the same cycle.
REQ-012 out_valid  output  1  biased result held in output register.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_data  output  DATA_W  acc_data + bias, signed.
REQ-015 out_idx  output  ADDR_W  neuron index of out_data.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse when pass complete.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, FIN.
REQ-019 IDLE: acc_ready=0; start=1 -> RUN with idx=0; start in any other state SHALL be ignored.
REQ-020 bias_addr SHALL equal idx in all states (0 in IDLE).
REQ-021 RUN: acc_ready = !out_valid || out_ready (single-register pipeline, full throughput).
REQ-022 Transfer (acc_valid && acc_ready) SHALL register out_data=acc_data+bias_data, out_idx=idx, out_valid=1, then idx+1; latency exactly 1 cycle.
REQ-023 Transfer with idx==N_NEURONS-1 SHALL go to DRAIN, idx stays N_NEURONS-1, acc_ready=0 thereafter.
REQ-024 out_valid SHALL clear on out_valid && out_ready without a simultaneous new transfer; out_data/out_idx SHALL hold while out_valid && !out_ready.
REQ-025 DRAIN: when out_valid==0 or out_valid && out_ready -> FIN.
REQ-026 FIN: done=1 for exactly that cycle, idx cleared to 0, -> IDLE.
REQ-027 Addition SHALL be computed at DATA_W+1 bits signed, result per Configuration.
REQ-028 acc_valid without acc_ready SHALL have no effect; acc_data need not be held stable by the block.

Reset
REQ-029 reset SHALL force IDLE, idx=0, out_valid=0, out_data=0, out_idx=0, done=0, busy=0, acc_ready=0 on the next clk edge, overriding any in-flight transfer or start.
REQ-030 Reset mid-pass SHALL discard the held output without a done pulse.

Configuration
REQ-031 Macro BIAS_ADD_SAT_EN defined: sums above 2^(DATA_W-1)-1 SHALL clamp to 0x7FFF, below -2^(DATA_W-1) clamp to 0x8000 (DATA_W=16).
REQ-032 BIAS_ADD_SAT_EN undefined: result SHALL be the low DATA_W bits of the sum (wrap-around).

Structure
REQ-033 Shared package mlp_pkg SHALL hold DATA_W, ADDR_W, N_NEURONS constants and the FSM state enum typedef.
REQ-034 Saturating/wrapping adder SHALL be sub-module bias_sat_add (combinational, macro-controlled); FSM, counter and output register stay in bias_add_seq.

Verification
REQ-035 Full pass, out_ready=1, acc_valid=1, acc_data=0x0010, bias[i]=i: outputs 0x0010..0x001E, out_idx 0..14 on consecutive cycles, done 2 cycles after last accept.
REQ-036 Backpressure: out_ready=0 for 3 cycles at idx=4 -> out_data/out_idx stable, acc_ready=0, no word lost or duplicated.
REQ-037 Saturation: acc_data=0x7FF0, bias=0x0020 -> 0x7FFF with BIAS_ADD_SAT_EN, 0x8010 without; acc_data=0x8000, bias=0xFFFF -> 0x8000 / 0x7FFF.
REQ-038 start pulsed during RUN at idx=7 -> ignored, pass continues to idx=14, single done.
REQ-039 reset asserted at idx=9 with out_valid=1 -> next cycle all outputs zero, busy=0, no done; fresh start restarts at idx=0.
REQ-040 acc_valid gaps (1 valid every 3 cycles) -> out_idx strictly increments by 1, bias_addr tracks idx.
